pwm_cfg_scheduler: RTL and testbench

//  Arbitrates configuration updates for one pwm_16bits channel among NREQ requesters (control loop, host

---
 rtl/pwm_cfg_scheduler_pkg.sv | 34 +++
 rtl/pwm_cfg_scheduler_rr_arbiter.sv | 48 ++++
 rtl/pwm_cfg_scheduler.sv | 177 +++++++++++++++++
 tb/tb_pwm_cfg_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cfg_scheduler_pkg.sv
// pwm_cfg_scheduler_pkg: shared types and clamp helpers for the PWM configuration scheduler.
// Rev 1.0
`default_nettype none

package pwm_cfg_scheduler_pkg;

  typedef enum logic [0:0] {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic [0:0] {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } _cfg_state;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_PERIOD_ZERO = 2'd1,
    ERR_TIMEOUT     = 2'd2
  } _cfg_err;

  function automatic logic [15:0] clamp_compare(input logic [15:0] cmp, input logic [15:0] per);
    return (cmp > per) ? per : cmp;
  endfunction

  // An out-of-range initial carrier restarts the carrier from zero rather than saturating.
  function automatic logic [15:0] clamp_init(input logic [15:0] init, input logic [15:0] per);
    return (init > per) ? 16'd0 : init;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_cfg_scheduler_rr_arbiter.sv
// pwm_cfg_scheduler_rr_arbiter: round-robin arbiter, priority starts one past the last granted index.
// Rev 1.0
`default_nettype none

module pwm_cfg_scheduler_rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic          found;
  int            pos;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = IW'(pos);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pwm_cfg_scheduler.sv
// pwm_cfg_scheduler: arbitrates and validates PWM channel config updates, commits them on a carrier
// boundary (or at once while off) and sequences pwm_onoff. Rev 1.0
`default_nettype none

module pwm_cfg_scheduler
  import pwm_cfg_scheduler_pkg::*;
#(
  parameter int          NREQ       = 2,
  parameter logic [15:0] DEF_PERIOD = 16'd999,
  parameter int          TIMEOUT    = 2**21
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*16-1:0]      req_period,
  input  logic [NREQ*16-1:0]      req_compare,
  input  logic [NREQ*16-1:0]      req_init_carr,
  input  logic                    run_en,
  input  logic                    sync_event,
  output logic [15:0]             period,
  output logic [15:0]             compare,
  output logic [15:0]             init_carr,
  output _pwm_onoff               pwm_onoff,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    commit_done,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic                    clamped
);

  localparam int          IW     = $clog2(NREQ);
  localparam int          TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

  _cfg_state state, state_nxt;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            accept;
  logic            commit_now;
  logic            timeout_hit;

  logic [15:0]     sel_period, sel_compare, sel_init;

  logic            shadow_full;
  logic [15:0]     sh_period, sh_compare, sh_init;

  logic [TW-1:0]   pend_cnt;
  logic [TW-1:0]   stop_cnt;

  pwm_cfg_scheduler_rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign sel_period  = req_period[16*arb_idx +: 16];
  assign sel_compare = req_compare[16*arb_idx +: 16];
  assign sel_init    = req_init_carr[16*arb_idx +: 16];
  assign accept      = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (reset) state <= CFG_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CFG_IDLE: if (shadow_full && pwm_onoff == PWM_ON) state_nxt = CFG_PEND;
      CFG_PEND: if (commit_now || timeout_hit) state_nxt = CFG_IDLE;
      default:  state_nxt = CFG_IDLE;
    endcase
  end

  // The validation cycle after an accept runs in IDLE with the shadow full, so a sync_event
  // there cannot commit; a channel that is (or has just gone) off commits without waiting.
  always_comb begin
    req_ready   = '0;
    commit_now  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      CFG_IDLE: begin
        if (!shadow_full) req_ready = arb_grant;
        commit_now = shadow_full && (pwm_onoff == PWM_OFF);
      end
      CFG_PEND: begin
        commit_now  = shadow_full && (sync_event || pwm_onoff == PWM_OFF);
        timeout_hit = !commit_now && (pend_cnt == T_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period      <= DEF_PERIOD;
      compare     <= '0;
      init_carr   <= '0;
      grant_id    <= '0;
      commit_done <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      clamped     <= 1'b0;
      shadow_full <= 1'b0;
      sh_period   <= '0;
      sh_compare  <= '0;
      sh_init     <= '0;
      pend_cnt    <= '0;
    end else begin
      commit_done <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      clamped     <= 1'b0;

      if (accept) begin
        if (sel_period == 16'd0) begin
          err      <= 1'b1;
          err_code <= ERR_PERIOD_ZERO;
        end else begin
          shadow_full <= 1'b1;
          sh_period   <= sel_period;
          sh_compare  <= clamp_compare(sel_compare, sel_period);
          sh_init     <= clamp_init(sel_init, sel_period);
          grant_id    <= arb_idx;
          clamped     <= (sel_compare > sel_period) || (sel_init > sel_period);
        end
      end

      if (commit_now) begin
        period      <= sh_period;
        compare     <= sh_compare;
        init_carr   <= sh_init;
        commit_done <= 1'b1;
        shadow_full <= 1'b0;
      end

      if (timeout_hit) begin
        shadow_full <= 1'b0;
        err         <= 1'b1;
        err_code    <= ERR_TIMEOUT;
      end

      if (state == CFG_PEND && state_nxt == CFG_PEND) begin
        if (pend_cnt != T_MAX) pend_cnt <= pend_cnt + 1'b1;
      end else begin
        pend_cnt <= '0;
      end
    end
  end

  // Start is immediate; a stop waits for the carrier boundary, bounded by the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_onoff <= PWM_OFF;
      stop_cnt  <= '0;
    end else if (run_en) begin
      pwm_onoff <= PWM_ON;
      stop_cnt  <= '0;
    end else if (pwm_onoff == PWM_ON) begin
      if (sync_event || stop_cnt == T_LAST) begin
        pwm_onoff <= PWM_OFF;
        stop_cnt  <= '0;
      end else if (stop_cnt != T_MAX) begin
        stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_cfg_scheduler.sv
// tb_pwm_cfg_scheduler: directed vector table plus hand-written multi-cycle sequences.
// Rev 1.0
`default_nettype none

module tb_pwm_cfg_scheduler;
  import pwm_cfg_scheduler_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req_period, req_compare, req_init_carr;
  logic        run_en, sync_event;
  logic [15:0] period, compare, init_carr;
  _pwm_onoff   pwm_onoff;
  logic [0:0]  grant_id;
  logic        commit_done, err, clamped;
  logic [1:0]  err_code;

  pwm_cfg_scheduler #(.NREQ(NREQ), .DEF_PERIOD(16'd999), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_period(req_period), .req_compare(req_compare), .req_init_carr(req_init_carr),
    .run_en(run_en), .sync_event(sync_event), .period(period), .compare(compare),
    .init_carr(init_carr), .pwm_onoff(pwm_onoff), .grant_id(grant_id),
    .commit_done(commit_done), .err(err), .err_code(err_code), .clamped(clamped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] p, c, i;
    logic [15:0] ep, ec, ei;
    bit          ecl;
    bit          eerr;
  } vec_t;

  vec_t tbl[6];
  int   errors, checks;
  int   rr;
  logic [15:0] mp, mc, mi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [15:0] p, input logic [15:0] c,
                      input logic [15:0] i, output bit ok);
    tick();
    req_period[16*id +: 16]    = p;
    req_compare[16*id +: 16]   = c;
    req_init_carr[16*id +: 16] = i;
    req_valid[id]              = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    if (!ok) chk("send_ready_timeout", 32'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok, got, rdy_seen, on_all, pulses;
    int commits, n;

    errors = 0; checks = 0; rr = 0;
    reset = 1'b1; req_valid = '0; req_period = '0; req_compare = '0; req_init_carr = '0;
    run_en = 1'b0; sync_event = 1'b0;

    tbl[0] = '{0, 16'd500,   16'd250,   16'd0,     16'd500,   16'd250,   16'd0,     1'b0, 1'b0};
    tbl[1] = '{1, 16'd100,   16'd200,   16'd150,   16'd100,   16'd100,   16'd0,     1'b1, 1'b0};
    tbl[2] = '{0, 16'd0,     16'd5,     16'd5,     16'd0,     16'd0,     16'd0,     1'b0, 1'b1};
    tbl[3] = '{1, 16'd65535, 16'd65535, 16'd65535, 16'd65535, 16'd65535, 16'd65535, 1'b0, 1'b0};
    tbl[4] = '{0, 16'd1,     16'd2,     16'd1,     16'd1,     16'd1,     16'd1,     1'b1, 1'b0};
    tbl[5] = '{1, 16'd300,   16'd300,   16'd301,   16'd300,   16'd300,   16'd0,     1'b1, 1'b0};

    repeat (3) tick();
    reset = 1'b0;

    // Reset state over 10 idle cycles
    pulses = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pulses |= commit_done | err | clamped;
    end
    chk("rst_period", period, 999);
    chk("rst_compare", compare, 0);
    chk("rst_init", init_carr, 0);
    chk("rst_onoff", 32'(pwm_onoff), 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_pulses", pulses, 0);
    mp = 16'd999; mc = 16'd0; mi = 16'd0;

    // Channel off: each request commits two cycles after accept
    for (int t = 0; t < 6; t++) begin
      send(tbl[t].id, tbl[t].p, tbl[t].c, tbl[t].i, ok);
      rr = (tbl[t].id + 1) % 2;
      @(negedge clk);
      chk($sformatf("vec%0d_err", t), err, tbl[t].eerr);
      chk($sformatf("vec%0d_clamped", t), clamped, tbl[t].ecl);
      chk($sformatf("vec%0d_early_commit", t), commit_done, 0);
      if (tbl[t].eerr) chk($sformatf("vec%0d_err_code", t), err_code, 1);
      else             chk($sformatf("vec%0d_grant", t), grant_id, tbl[t].id);
      @(negedge clk);
      chk($sformatf("vec%0d_commit", t), commit_done, !tbl[t].eerr);
      if (!tbl[t].eerr) begin
        mp = tbl[t].ep; mc = tbl[t].ec; mi = tbl[t].ei;
      end
      chk($sformatf("vec%0d_period", t), period, mp);
      chk($sformatf("vec%0d_compare", t), compare, mc);
      chk($sformatf("vec%0d_init", t), init_carr, mi);
    end

    // Channel on, two requesters, sync_event in accept and validation cycles
    run_en = 1'b1;
    tick();
    @(negedge clk);
    chk("run_on", 32'(pwm_onoff), 1);
    tick();
    req_period    = {16'd800, 16'd700};
    req_compare   = {16'd400, 16'd350};
    req_init_carr = {16'd20,  16'd10};
    req_valid     = 2'b11;
    @(negedge clk);
    chk("rr_first", req_ready, (rr == 0) ? 2'b01 : 2'b10);
    sync_event = 1'b1;
    commits = 0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    commits += commit_done;
    chk("validate_ready_low", req_ready, 0);
    @(posedge clk); #1;
    sync_event = 1'b0;
    rdy_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      commits += commit_done;
      rdy_seen |= |req_ready;
    end
    chk("pend_no_commit", commits, 0);
    chk("pend_ready_low", rdy_seen, 0);
    chk("pend_period_held", period, mp);
    @(posedge clk); #1;
    sync_event = 1'b1;
    @(posedge clk); #1;
    sync_event = 1'b0;
    @(negedge clk);
    chk("sync_commit", commit_done, 1);
    chk("sync_period", period, 700);
    chk("sync_compare", compare, 350);
    chk("sync_init", init_carr, 10);
    chk("sync_grant", grant_id, 0);
    chk("rr_second", req_ready, 2'b10);
    mp = 16'd700; mc = 16'd350; mi = 16'd10;

    // Requester 1 now pends with no sync_event until timeout
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    got = 1'b0; n = 0; commits = 0;
    for (int k = 1; k <= TIMEOUT + 10; k++) begin
      @(negedge clk);
      commits += commit_done;
      if (err) begin
        got = 1'b1;
        n = k;
        chk("to_err_code", err_code, 2);
        break;
      end
    end
    chk("to_seen", got, 1);
    chk("to_window", (n >= TIMEOUT && n <= TIMEOUT + 4), 1);
    chk("to_no_commit", commits, 0);
    chk("to_period_held", period, mp);
    chk("to_compare_held", compare, mc);
    chk("to_init_held", init_carr, mi);

    // run_en falls mid-period with a commit pending; both land on the same sync_event
    send(0, 16'd600, 16'd300, 16'd5, ok);
    run_en = 1'b0;
    on_all = 1'b1; commits = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      on_all &= (pwm_onoff == PWM_ON);
      commits += commit_done;
    end
    chk("stop_hold_on", on_all, 1);
    chk("stop_no_commit", commits, 0);
    @(posedge clk); #1;
    sync_event = 1'b1;
    @(posedge clk); #1;
    sync_event = 1'b0;
    @(negedge clk);
    chk("stop_commit", commit_done, 1);
    chk("stop_off", 32'(pwm_onoff), 0);
    chk("stop_period", period, 600);
    chk("stop_compare", compare, 300);
    chk("stop_init", init_carr, 5);

    // Reset while a request is pending drops the shadow
    run_en = 1'b1;
    send(1, 16'd900, 16'd450, 16'd30, ok);
    tick();
    reset = 1'b1; run_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("prst_period", period, 999);
    chk("prst_compare", compare, 0);
    chk("prst_init", init_carr, 0);
    chk("prst_onoff", 32'(pwm_onoff), 0);
    chk("prst_grant", grant_id, 0);
    @(posedge clk); #1;
    sync_event = 1'b1;
    tick();
    sync_event = 1'b0;
    commits = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      commits += commit_done;
    end
    chk("prst_no_commit", commits, 0);
    chk("prst_period_after_sync", period, 999);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
